// File: rtl/wb_target_arbiter.sv
// Wishbone slave-port arbiter: decodes the address to one of two targets, runs a single
// outstanding transfer with timeout, and returns a registered ack/data to the master.
module wb_target_arbiter #(
  parameter logic [31:0] T0_BASE  = 32'h3800_0000,
  parameter logic [31:0] T0_MASK  = 32'hFFC0_0000,
  parameter logic [31:0] T1_BASE  = 32'h3000_0000,
  parameter logic [31:0] T1_MASK  = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        t0_cyc_o,
  output logic        t0_stb_o,
  input  logic        t0_ack_i,
  input  logic [31:0] t0_dat_i,
  output logic        t1_cyc_o,
  output logic        t1_stb_o,
  input  logic        t1_ack_i,
  input  logic [31:0] t1_dat_i,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata;
  logic          t0_req;
  logic          t1_req;
  logic          t0_hit;
  logic          t1_hit;
  logic          sel_ack;
  logic [31:0]   sel_dat;

  assign t0_cyc_o = t0_req;
  assign t0_stb_o = t0_req;
  assign t1_cyc_o = t1_req;
  assign t1_stb_o = t1_req;

  always_comb begin
    t0_hit  = (wbs_adr_i & T0_MASK) == T0_BASE;
    t1_hit  = (wbs_adr_i & T1_MASK) == T1_BASE;
    sel_ack = (t0_req & t0_ack_i) | (t1_req & t1_ack_i);
    sel_dat = t0_req ? t0_dat_i : t1_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      t0_req    <= 1'b0;
      t1_req    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      // Clear first so that a same-edge set below takes priority.
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          // The master still holds stb during the ack cycle; do not take that as a new request.
          if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
            m_we_o  <= wbs_we_i;
            m_sel_o <= wbs_sel_i;
            m_adr_o <= wbs_adr_i;
            m_dat_o <= wbs_dat_i;
            busy_o  <= 1'b1;
            cnt     <= '0;
            if (t0_hit) begin
              t0_req <= 1'b1;
              state  <= REQ;
            end else if (t1_hit) begin
              t1_req <= 1'b1;
              state  <= REQ;
            end else begin
              rdata <= ERR_DATA;
              err_o <= 1'b1;
              state <= RESP;
            end
          end
        end
        REQ: begin
          if (!wbs_cyc_i) begin
            t0_req <= 1'b0;
            t1_req <= 1'b0;
            cnt    <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (sel_ack) begin
            t0_req <= 1'b0;
            t1_req <= 1'b0;
            rdata  <= m_we_o ? '0 : sel_dat;
            state  <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            t0_req <= 1'b0;
            t1_req <= 1'b0;
            rdata  <= ERR_DATA;
            err_o  <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= rdata;
          cnt       <= '0;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_target_arbiter.sv
// Bench for wb_target_arbiter: vector table, corner-case sequences and random
// transactions checked against a transaction-level latency/response model.
module tb_wb_target_arbiter;

  localparam int          TO       = 4;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat;
  logic        t0_cyc, t0_stb, t1_cyc, t1_stb;
  logic        t0_ack = 1'b0, t1_ack = 1'b0;
  logic [31:0] t0_dat = '0, t1_dat = '0;
  logic        err_clr = 1'b0;
  logic        err, busy;

  int checks = 0;
  int failures = 0;

  wb_target_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .m_we_o(m_we), .m_sel_o(m_sel), .m_adr_o(m_adr), .m_dat_o(m_dat),
    .t0_cyc_o(t0_cyc), .t0_stb_o(t0_stb), .t0_ack_i(t0_ack), .t0_dat_i(t0_dat),
    .t1_cyc_o(t1_cyc), .t1_stb_o(t1_stb), .t1_ack_i(t1_ack), .t1_dat_i(t1_dat),
    .err_clr_i(err_clr), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] adr;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          d;      // target ack sampled this many edges after E0 (0 = never)
    logic [31:0] tdat;
    int          tgt;    // 0, 1, or 2 = no target
    int          k;      // wbs_ack_o seen after edge E0+k
    logic [31:0] data;
    bit          err;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: which target, when the master sees ack, with what data.
  function automatic void model(inout vec_t v);
    bit h0, h1;
    h0 = (v.adr & 32'hFFC0_0000) == 32'h3800_0000;
    h1 = (v.adr & 32'hFFFF_0000) == 32'h3000_0000;
    if (!h0 && !h1) begin
      v.tgt = 2; v.k = 1; v.data = ERR_WORD; v.err = 1'b1;
    end else begin
      v.tgt = h0 ? 0 : 1;
      if (v.d >= 1 && v.d <= TO + 1) begin
        v.k = v.d + 1; v.data = v.we ? 32'h0 : v.tdat; v.err = 1'b0;
      end else begin
        v.k = TO + 2; v.data = ERR_WORD; v.err = 1'b1;
      end
    end
  endfunction

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", err, 1'b0);
  endtask

  // Called just after a posedge with the bus idle; E0 is the next posedge.
  task automatic run_txn(input vec_t v, input string tag);
    int acks = 0, ack_k = -1, cnt0 = 0, cnt1 = 0, drop_at = -1;
    bit wrong = 1'b0, bad_dat = 1'b0;
    logic [31:0] seen = '0;
    cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.dat;
    t0_ack = (v.tgt == 0) ? 1'b0 : 1'($urandom);
    t1_ack = (v.tgt == 1) ? 1'b0 : 1'($urandom);
    t0_dat = (v.tgt == 0) ? v.tdat : $urandom;
    t1_dat = (v.tgt == 1) ? v.tdat : $urandom;
    for (int kk = 0; kk < TO + 12; kk++) begin
      @(posedge clk); #1;
      if (kk == 0) begin
        chk({tag, "_m_bus"}, {m_we, m_sel, m_adr, m_dat}, {v.we, v.sel, v.adr, v.dat});
        chk({tag, "_busy"}, busy, 1'b1);
      end
      if (ack) begin acks++; ack_k = kk; seen = rdat; end
      else if (rdat !== 32'h0) bad_dat = 1'b1;
      if (t0_cyc !== t0_stb || t1_cyc !== t1_stb) wrong = 1'b1;
      if (v.tgt != 0 && t0_stb) wrong = 1'b1;
      if (v.tgt != 1 && t1_stb) wrong = 1'b1;
      if (drop_at == kk) begin cyc = 1'b0; stb = 1'b0; end
      if (ack) drop_at = kk + 1;
      if (t0_stb) cnt0++;
      if (t1_stb) cnt1++;
      t0_ack = (v.tgt == 0) ? (t0_stb && cnt0 == v.d) : 1'($urandom);
      t1_ack = (v.tgt == 1) ? (t1_stb && cnt1 == v.d) : 1'($urandom);
    end
    t0_ack = 1'b0; t1_ack = 1'b0; cyc = 1'b0; stb = 1'b0;
    chk({tag, "_ack_count"}, acks, 1);
    chk({tag, "_ack_cycle"}, ack_k, v.k);
    chk({tag, "_ack_data"}, seen, v.data);
    chk({tag, "_err"}, err, v.err);
    chk({tag, "_strobe_target"}, wrong, 1'b0);
    chk({tag, "_dat_idle_zero"}, bad_dat, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    if (v.err) clear_err();
  endtask

  function automatic logic [127:0] all_outs();
    return {ack, rdat, m_we, m_sel, m_adr, m_dat, t0_cyc, t0_stb, t1_cyc, t1_stb, err, busy};
  endfunction

  vec_t vecs[7];
  vec_t rv;
  int   acks;

  initial begin
    //            adr           we    sel   dat            d  tdat          tgt k  data          err
    vecs[0] = '{32'h3800_0010, 1'b0, 4'hF, 32'h0,         1, 32'h1234_5678, 0, 2, 32'h1234_5678, 1'b0};
    vecs[1] = '{32'h3000_0004, 1'b1, 4'hF, 32'h0000_00A5, 3, 32'h5555_AAAA, 1, 4, 32'h0,         1'b0};
    vecs[2] = '{32'h2000_0000, 1'b0, 4'hF, 32'h0,         1, 32'h1111_1111, 2, 1, ERR_WORD,      1'b1};
    vecs[3] = '{32'h3800_0000, 1'b0, 4'h3, 32'h0,         0, 32'h2222_2222, 0, 6, ERR_WORD,      1'b1};
    vecs[4] = '{32'h3000_FFFC, 1'b0, 4'hF, 32'h0,         5, 32'hCAFE_F00D, 1, 6, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{32'h3840_0000, 1'b1, 4'h1, 32'h7777_0000, 1, 32'h3333_3333, 2, 1, ERR_WORD,      1'b1};
    vecs[6] = '{32'h3000_0000, 1'b0, 4'hF, 32'h0,         6, 32'h4444_4444, 1, 6, ERR_WORD,      1'b1};

    #3;
    chk("reset_outputs", all_outs(), 128'h0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_outputs", all_outs(), 128'h0);

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Master abort on the same edge as the target ack.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3800_0020; t0_dat = 32'h9999_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_strobe_before", t0_stb, 1'b1);
    t0_ack = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    t0_ack = 1'b0;
    chk("abort_idle", {busy, t0_stb, t1_stb}, 3'b000);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    run_txn(vecs[0], "after_abort");

    // Reset pulse while a T1 request is outstanding.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_strobe_before", t1_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", all_outs(), 128'h0);
    cyc = 1'b0; stb = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(vecs[0], "after_reset");

    // err_clr on the same edge as a decode miss: set wins.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000_0000; err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_set_wins", err, 1'b1);
    @(posedge clk); #1;
    chk("miss_ack", {ack, rdat}, {1'b1, ERR_WORD});
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    chk("miss_no_rerun", busy, 1'b0);
    clear_err();

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: rv.adr = 32'h3800_0000 | ($urandom & 32'h003F_FFFC);
        1: rv.adr = 32'h3000_0000 | ($urandom & 32'h0000_FFFC);
        default: rv.adr = $urandom;
      endcase
      rv.we   = 1'($urandom);
      rv.sel  = 4'($urandom);
      rv.dat  = $urandom;
      rv.d    = $urandom_range(0, 7);
      rv.tdat = $urandom;
      model(rv);
      run_txn(rv, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
